// File: rtl/fft_color_mapper_pkg.sv
// Shared definitions for the FFT colour mapper: RGB444/level/offset widths,
// the frame sequencer state encoding and the palette channel scaler.
package fft_color_pkg;
  localparam int CH_W    = 4;
  localparam int COLOR_W = 3 * CH_W;
  localparam int LVL_W   = 4;
  localparam logic [LVL_W-1:0] LVL_MAX = 4'd15;
  localparam int OFF_W   = 4;

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, SCALE, DONE} state_t;

  // Each channel becomes (pal_ch * lvl) >> 4, so full scale tops out at 14.
  function automatic logic [COLOR_W-1:0] scale_color(input logic [COLOR_W-1:0] pal,
                                                     input logic [LVL_W-1:0]   lvl);
    logic [CH_W+LVL_W-1:0] p;
    logic [COLOR_W-1:0]    c;
    c = '0;
    for (int i = 0; i < 3; i++) begin
      p = {{LVL_W{1'b0}}, pal[i*CH_W +: CH_W]} * {{CH_W{1'b0}}, lvl};
      c[i*CH_W +: CH_W] = p[CH_W+LVL_W-1 -: CH_W];
    end
    return c;
  endfunction
endpackage

// File: rtl/fft_color_mapper_if.sv
// BRAM read bus between the colour mapper (master) and the FFT magnitude
// BRAM (slave).
//   bram_addr : read address from the mapper
//   bram_data : signed sample, valid a fixed latency after its address
interface fft_color_mapper_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] bram_addr;
  logic [DATA_W-1:0] bram_data;

  modport master (output bram_addr, input bram_data);
  modport slave  (input bram_addr, output bram_data);
endinterface

// File: rtl/fft_color_mapper_offset_bank.sv
// Per-bin saturating 4-bit shift offsets driven by the up/down buttons.
//   adj_sel   : bin being adjusted; values >= NUM_BINS select nothing
//   up/down   : one-cycle pulses; both together cancel
//   offsets   : current offsets, bin 0 in the LSBs
//   adjusting : high the cycle after an offset actually moved
module offset_bank
  import fft_color_pkg::*;
#(
  parameter int NUM_BINS = 7,
  parameter int OFF_INIT = 4,
  parameter int SEL_W    = 3
)(
  input  logic                           clock,
  input  logic                           reset,
  input  logic [SEL_W-1:0]               adj_sel,
  input  logic                           up,
  input  logic                           down,
  output logic [NUM_BINS-1:0][OFF_W-1:0] offsets,
  output logic                           adjusting
);
  logic [NUM_BINS-1:0] changed;

  for (genvar i = 0; i < NUM_BINS; i++) begin : g_off
    logic [OFF_W-1:0] off_q;
    logic sel, inc, dec;
    assign sel        = adj_sel == SEL_W'(i);
    // Saturated moves are suppressed here so they never raise adjusting.
    assign inc        = sel & up & ~down & (off_q != '1);
    assign dec        = sel & down & ~up & (off_q != '0);
    assign changed[i] = inc | dec;
    assign offsets[i] = off_q;

    always_ff @(posedge clock or negedge reset)
      if (!reset)   off_q <= OFF_W'(OFF_INIT);
      else if (inc) off_q <= off_q + 1'b1;
      else if (dec) off_q <= off_q - 1'b1;
  end

  always_ff @(posedge clock or negedge reset)
    if (!reset) adjusting <= 1'b0;
    else        adjusting <= |changed;
endmodule

// File: rtl/fft_color_mapper.sv
// FFT energy to colour mapper. On start, walks NUM_BINS BRAM address ranges,
// sums |sample| per bin, turns each sum into a 4-bit level using a
// button-adjustable shift offset, scales the bin's palette colour by it and
// publishes all bins at once with a one-cycle color_valid.
//   clock/reset        : clock, async active-low reset
//   start              : begin a frame (ignored while busy)
//   bin_start/bin_end  : inclusive address range per bin, bin 0 in LSBs
//   bram               : BRAM read bus (master)
//   adj_sel/up/down    : offset buttons; adjusting/offsets reflect them
//   busy               : frame in progress
//   color/levels       : published RGB444 colours and levels
//   color_valid        : one-cycle pulse when color/levels update
// Optional: define FFT_COLOR_PEAK_HOLD_EN for per-bin peak hold with decay of
// one level per frame.
module fft_color_mapper
  import fft_color_pkg::*;
#(
  parameter int NUM_BINS   = 7,
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int BRAM_LAT   = 2,
  parameter int SHIFT_BASE = 8,
  parameter int OFF_INIT   = 4,
  parameter logic [NUM_BINS*COLOR_W-1:0] PALETTE = 84'hFFF_FF0_F0F_00F_0F0_D08_0FF
)(
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [NUM_BINS-1:0][ADDR_W-1:0]  bin_start,
  input  logic [NUM_BINS-1:0][ADDR_W-1:0]  bin_end,
  fft_color_mapper_if.master               bram,
  input  logic [$clog2(NUM_BINS)-1:0]      adj_sel,
  input  logic                             up,
  input  logic                             down,
  output logic                             adjusting,
  output logic [NUM_BINS-1:0][OFF_W-1:0]   offsets,
  output logic                             busy,
  output logic [NUM_BINS-1:0][COLOR_W-1:0] color,
  output logic [NUM_BINS-1:0][LVL_W-1:0]   levels,
  output logic                             color_valid
);
  localparam int SEL_W = $clog2(NUM_BINS);
  localparam int ACC_W = DATA_W + ADDR_W;
  localparam int CNT_W = $clog2(BRAM_LAT + 1);
  localparam logic [NUM_BINS-1:0][COLOR_W-1:0] PAL = PALETTE;

  state_t state, state_nxt;
  logic [NUM_BINS-1:0][ADDR_W-1:0]  start_lat, end_lat;
  logic [NUM_BINS-1:0][COLOR_W-1:0] color_sh, color_nxt;
  logic [NUM_BINS-1:0][LVL_W-1:0]   lvl_sh, lvl_nxt;
  logic [ADDR_W-1:0] addr;
  logic [SEL_W-1:0]  b;
  logic [CNT_W-1:0]  drain_cnt;
  logic [BRAM_LAT:1] vld_pipe;
  logic [ACC_W-1:0]  acc, shifted;
  logic [DATA_W-1:0] mag;
  logic [LVL_W-1:0]  new_lvl, pub_lvl;
  logic issue, empty, last_addr, last_bin;

  assign bram.bram_addr = addr;
  assign empty     = start_lat[b] > end_lat[b];
  assign last_addr = addr == end_lat[b];
  assign last_bin  = b == SEL_W'(NUM_BINS - 1);

  offset_bank #(.NUM_BINS(NUM_BINS), .OFF_INIT(OFF_INIT), .SEL_W(SEL_W)) u_off (
    .clock(clock), .reset(reset), .adj_sel(adj_sel), .up(up), .down(down),
    .offsets(offsets), .adjusting(adjusting)
  );

  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = FETCH;
      FETCH: begin
        // An empty bin (start > end) spends one cycle here without reading.
        issue = !empty;
        if (empty || last_addr) state_nxt = DRAIN;
      end
      DRAIN: if (drain_cnt == CNT_W'(BRAM_LAT - 1)) state_nxt = SCALE;
      SCALE: state_nxt = last_bin ? DONE : FETCH;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // |sample|, with the most negative code clamped to the largest positive.
  always_comb begin
    if (bram.bram_data == {1'b1, {(DATA_W-1){1'b0}}}) mag = {1'b0, {(DATA_W-1){1'b1}}};
    else if (bram.bram_data[DATA_W-1])                mag = -bram.bram_data;
    else                                              mag = bram.bram_data;
  end

  // Level/colour of the current bin; offset is sampled in its SCALE cycle.
  always_comb begin
    shifted = acc >> (SHIFT_BASE + int'(offsets[b]));
    new_lvl = (shifted > ACC_W'(LVL_MAX)) ? LVL_MAX : shifted[LVL_W-1:0];
    pub_lvl = new_lvl;
`ifdef FFT_COLOR_PEAK_HOLD_EN
    if (levels[b] != '0 && (levels[b] - 1'b1) > new_lvl) pub_lvl = levels[b] - 1'b1;
`endif
    lvl_nxt      = lvl_sh;
    lvl_nxt[b]   = pub_lvl;
    color_nxt    = color_sh;
    color_nxt[b] = scale_color(PAL[b], pub_lvl);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      start_lat   <= '0;
      end_lat     <= '0;
      addr        <= '0;
      b           <= '0;
      drain_cnt   <= '0;
      vld_pipe    <= '0;
      acc         <= '0;
      color_sh    <= '0;
      lvl_sh      <= '0;
      color       <= '0;
      levels      <= '0;
      color_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      // vld_pipe[k] tags the address issued k cycles ago.
      vld_pipe[1] <= issue;
      for (int k = 2; k <= BRAM_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
      color_valid <= 1'b0;
      if (vld_pipe[BRAM_LAT]) acc <= acc + ACC_W'(mag);
      case (state)
        IDLE: if (start) begin
          start_lat <= bin_start;
          end_lat   <= bin_end;
          addr      <= bin_start[0];
          b         <= '0;
          acc       <= '0;
          busy      <= 1'b1;
        end
        FETCH: begin
          drain_cnt <= '0;
          if (!empty && !last_addr) addr <= addr + 1'b1;
        end
        DRAIN: drain_cnt <= drain_cnt + 1'b1;
        SCALE: begin
          color_sh <= color_nxt;
          lvl_sh   <= lvl_nxt;
          acc      <= '0;
          // Publishing on the last SCALE edge makes color_valid coincide
          // with DONE and drops busy in the same cycle.
          if (last_bin) begin
            color       <= color_nxt;
            levels      <= lvl_nxt;
            color_valid <= 1'b1;
            busy        <= 1'b0;
          end else begin
            b    <= b + 1'b1;
            addr <= start_lat[b + 1'b1];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fft_color_mapper.sv
module tb_fft_color_mapper;
  logic clock, reset_n, start, up, down;
  logic [6:0][9:0]  bin_start, bin_end;
  logic [2:0]       adj_sel;
  logic             adjusting, busy, color_valid;
  logic [6:0][3:0]  offsets, levels;
  logic [6:0][11:0] color;

  fft_color_mapper_if #(.ADDR_W(10), .DATA_W(16)) bus ();

  fft_color_mapper #(.NUM_BINS(7), .DATA_W(16), .ADDR_W(10), .BRAM_LAT(2),
                     .SHIFT_BASE(8), .OFF_INIT(4)) dut (
    .clock(clock), .reset(reset_n), .start(start), .bin_start(bin_start),
    .bin_end(bin_end), .bram(bus), .adj_sel(adj_sel), .up(up), .down(down),
    .adjusting(adjusting), .offsets(offsets), .busy(busy), .color(color),
    .levels(levels), .color_valid(color_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Two-cycle-latency BRAM model.
  logic [15:0] mem [1024];
  logic [15:0] rd1, rd2;
  always @(posedge clock) begin
    rd1 <= mem[bus.bram_addr];
    rd2 <= rd1;
  end
  assign bus.bram_data = rd2;

  int errors, checks;
  logic [3:0] off_m [7];

  typedef struct {
    logic [15:0] val;    // value stored at every address of every bin
    int          len;    // words per bin, bins laid out contiguously
    int          base;   // first address of bin 0
    bit          empty3; // bin 3 becomes start=20, end=10
    logic [3:0]  off;    // offset applied to every bin
    logic [27:0] lvl;
    logic [83:0] col;
    int          lat;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [27:0] off_pack();
    logic [27:0] p;
    for (int i = 0; i < 7; i++) p[i*4 +: 4] = off_m[i];
    return p;
  endfunction

  task automatic pulse(input int sel, input bit u, input bit d, output logic adj);
    @(negedge clock);
    adj_sel = 3'(sel); up = u; down = d;
    @(negedge clock);
    up = 1'b0; down = 1'b0;
    adj = adjusting;
    if (sel < 7 && u != d) begin
      if (u && off_m[sel] != 4'hF)      off_m[sel] = off_m[sel] + 4'd1;
      else if (d && off_m[sel] != 4'h0) off_m[sel] = off_m[sel] - 4'd1;
    end
  endtask

  task automatic set_offsets(input logic [3:0] target);
    logic adj;
    for (int i = 0; i < 7; i++)
      while (off_m[i] != target) pulse(i, off_m[i] < target, off_m[i] > target, adj);
  endtask

  task automatic setup(input int v);
    int s;
    set_offsets(tbl[v].off);
    for (int a = 0; a < 1024; a++) mem[a] = 16'h7FFF;
    for (int i = 0; i < 7; i++) begin
      s = tbl[v].base + i * tbl[v].len;
      if (tbl[v].empty3 && i == 3) begin
        bin_start[i] = 10'd20;
        bin_end[i]   = 10'd10;
      end else begin
        bin_start[i] = 10'(s);
        bin_end[i]   = 10'(s + tbl[v].len - 1);
        for (int a = s; a < s + tbl[v].len; a++) mem[a] = tbl[v].val;
      end
    end
  endtask

  task automatic run_frame(input int budget, output int lat, output logic busy1);
    lat = -1; busy1 = 1'b0;
    @(negedge clock);
    start = 1'b1;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clock);
      start = 1'b0;
      if (k == 1) busy1 = busy;
      if (color_valid) begin lat = k; break; end
    end
  endtask

  task automatic apply_check(input int v);
    int lat;
    logic b1;
    setup(v);
    chk($sformatf("v%0d_offsets", v), offsets, off_pack());
    run_frame(400, lat, b1);
    chk($sformatf("v%0d_latency", v), lat, tbl[v].lat);
    chk($sformatf("v%0d_busy_accept", v), b1, 1);
    chk($sformatf("v%0d_levels", v), levels, tbl[v].lvl);
    chk($sformatf("v%0d_color", v), color, tbl[v].col);
    chk($sformatf("v%0d_busy_done", v), busy, 0);
    @(negedge clock);
    chk($sformatf("v%0d_valid_one_cycle", v), color_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, first;
    logic adj;
    errors = 0; checks = 0;
    start = 0; up = 0; down = 0; adj_sel = '0;
    bin_start = '0; bin_end = '0;
    for (int i = 0; i < 7; i++) off_m[i] = 4'd4;
    for (int a = 0; a < 1024; a++) mem[a] = 16'h7FFF;

    tbl[0] = '{16'h0100,  8,   0, 1'b0, 4'd0, 28'h8888888, 84'h777_770_707_007_070_604_077,  78};
    tbl[1] = '{16'h7FFF,  1,   0, 1'b0, 4'd0, 28'hFFFFFFF, 84'hEEE_EE0_E0E_00E_0E0_C07_0EE,  29};
    tbl[2] = '{16'hFF00,  8,   0, 1'b0, 4'd0, 28'h8888888, 84'h777_770_707_007_070_604_077,  78};
    tbl[3] = '{16'h0010, 16,   0, 1'b0, 4'd0, 28'h1111111, 84'h0,                           134};
    tbl[4] = '{16'h8000,  3,   0, 1'b0, 4'd0, 28'hFFFFFFF, 84'hEEE_EE0_E0E_00E_0E0_C07_0EE,  43};
    tbl[5] = '{16'h0100, 12,   0, 1'b0, 4'd0, 28'hCCCCCCC, 84'hBBB_BB0_B0B_00B_0B0_906_0BB, 106};
    tbl[6] = '{16'h0000,  4,   0, 1'b0, 4'd0, 28'h0,       84'h0,                            50};
    tbl[7] = '{16'h8000,  1, 100, 1'b1, 4'd4, 28'h7770777, 84'h666_660_606_000_060_503_066,  29};
    tbl[8] = '{16'h0100,  8,   0, 1'b0, 4'd4, 28'h0,       84'h0,                            78};

    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_color", color, 0);
    chk("rst_levels", levels, 0);
    chk("rst_valid", color_valid, 0);
    chk("rst_adjusting", adjusting, 0);
    chk("rst_offsets", offsets, 28'h4444444);
    chk("rst_addr", bus.bram_addr, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // Offset buttons.
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      pulse(2, 1, 0, adj);
      if (adj) cnt++;
    end
    chk("adj_pulse_count", cnt, 11);
    chk("off2_saturated", offsets[2], 15);
    pulse(1, 1, 1, adj);
    chk("updown_adjusting", adj, 0);
    chk("updown_off1", offsets[1], 4);
    pulse(7, 1, 0, adj);
    chk("sel7_adjusting", adj, 0);
    chk("sel7_offsets", offsets, off_pack());
    pulse(2, 0, 1, adj);
    chk("down_adjusting", adj, 1);
    chk("down_off2", offsets[2], 14);
    set_offsets(4'd0);
    pulse(0, 0, 1, adj);
    chk("floor_adjusting", adj, 0);
    chk("floor_off0", offsets[0], 0);

    for (int v = 0; v < 9; v++) apply_check(v);

    // start pulses while busy, including the last SCALE and DONE cycles.
    setup(0);
    cnt = 0; first = -1;
    @(negedge clock);
    start = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clock);
      start = (k == 10 || k == 30 || k == 77 || k == 78);
      if (color_valid) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    start = 1'b0;
    chk("busy_start_valid_count", cnt, 1);
    chk("busy_start_latency", first, 78);
    chk("busy_start_idle", busy, 0);

    // Reset during FETCH of bin 4.
    setup(0);
    @(negedge clock);
    start = 1'b1;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clock);
      start = 1'b0;
    end
    chk("pre_abort_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_color", color, 0);
    chk("abort_levels", levels, 0);
    chk("abort_valid", color_valid, 0);
    chk("abort_addr", bus.bram_addr, 0);
    chk("abort_offsets", offsets, 28'h4444444);
    for (int i = 0; i < 7; i++) off_m[i] = 4'd4;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock);
      if (color_valid) cnt++;
    end
    chk("abort_no_valid", cnt, 0);
    chk("abort_idle", busy, 0);
    apply_check(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fft_color_mapper.md
Name: fft_color_mapper

Overview:
- Parametrised successor to the fixed 7-bin FFT-energy-to-colour stage feeding the VGA colour output.
- On each `start`, walks NUM_BINS address ranges in the FFT magnitude BRAM and accumulates |sample| per bin.
- Converts each sum into a 4-bit level using a per-bin, button-adjustable shift offset, then scales a per-bin base palette colour by that level.
- Publishes all bin colours at once as a packed vector with a one-cycle valid pulse.

Parameters:
- NUM_BINS, 7, number of frequency bins/colours.
- DATA_W, 16, BRAM sample width, signed two's complement.
- ADDR_W, 10, BRAM address width.
- BRAM_LAT, 2, BRAM read latency in cycles, 1..3.
- SHIFT_BASE, 8, fixed right-shift added to every bin offset.
- OFF_INIT, 4, reset value of every offset, 0..15.
- PALETTE, 84'hFFF_FF0_F0F_00F_0F0_D08_0FF, NUM_BINS*12 base RGB444 colours; bin 0 in the LSBs.

Ports:
- clock  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse; begin one frame of bins.
- bin_start  in  NUM_BINS*ADDR_W  first address of each bin, bin 0 in the LSBs.
- bin_end  in  NUM_BINS*ADDR_W  last address of each bin (inclusive).
- bram_addr  out  ADDR_W  BRAM read address.
- bram_data  in  DATA_W  BRAM read data, valid BRAM_LAT cycles after its address.
- adj_sel  in  $clog2(NUM_BINS)  bin whose offset the buttons adjust.
- up  in  1  pulse; increment the offset of adj_sel.
- down  in  1  pulse; decrement the offset of adj_sel.
- adjusting  out  1  high for one cycle after any offset change.
- offsets  out  NUM_BINS*4  current offsets, for the hex display.
- busy  out  1  high from start acceptance until color_valid.
- color  out  NUM_BINS*12  packed RGB444 colours.
- levels  out  NUM_BINS*4  packed bin levels.
- color_valid  out  1  one-cycle pulse when color and levels update.

Behaviour:
- Reset values: bram_addr=0, busy=0, color=0, levels=0, color_valid=0, adjusting=0, all offsets=OFF_INIT. State machine returns to IDLE.
- States:
  - IDLE: start=1 latches bin_start/bin_end, sets busy=1, sets bin index b=0, goes to FETCH. start is ignored in every non-IDLE state.
  - FETCH: issues one address per cycle from start_b to end_b inclusive, so L_b = end_b - start_b + 1 cycles. If start_b > end_b the bin is empty: one idle cycle, no address issued, acc=0.
  - DRAIN: BRAM_LAT cycles so the last sample returns.
  - SCALE: one cycle. Computes the level and colour of bin b into a shadow register. If b = NUM_BINS-1, goes to DONE; else b+1 and back to FETCH.
  - DONE: copies shadows to color/levels, color_valid=1, busy=0, goes to IDLE.
- Latency: color_valid asserts exactly 1 + Σ_b(max(L_b,1) + BRAM_LAT + 1) cycles after the start cycle.
- Accumulation: a valid-tag shift register of depth BRAM_LAT marks returning data. acc (DATA_W+ADDR_W bits, cleared per bin) += |bram_data|. |−2^(DATA_W−1)| saturates to 2^(DATA_W−1)−1. Addresses are never wrapped or clipped.
- Level: lvl = min(acc >> (SHIFT_BASE + off_b), 15).
- Colour: each 4-bit channel = (pal_ch × lvl) >> 4, truncated, giving 0..14 when pal_ch=15 and lvl=15. lvl=0 gives black.
- Offsets: 4-bit, saturating at 0 and 15, updated in any state.
  - up and down in the same cycle: no change, adjusting stays 0.
  - adj_sel ≥ NUM_BINS: pulse ignored.
  - The offset used by a bin is sampled at that bin's SCALE cycle.
  - adjusting pulses the cycle after an actual change; no pulse when saturated.
- Reset asserted mid-frame: immediate abort, all outputs to reset values, no color_valid.

Optional Feature:
- Macro: FFT_COLOR_PEAK_HOLD_EN.
- Defined: per-bin peak-hold decay; published lvl = max(new_lvl, prev_lvl − 1), where prev_lvl is the last published level (0 after reset).
- Undefined: published lvl = new_lvl. No extra state registers.

Decomposition:
- Shared package fft_color_pkg:
  - RGB444 channel width constant (4) and colour width (12).
  - Level width (4) and LVL_MAX = 15.
  - Offset width (4).
  - State encoding enum {IDLE, FETCH, DRAIN, SCALE, DONE}.
- One sub-module, offset_bank: holds the NUM_BINS saturating up/down offset registers and generates adjusting. The mapper instantiates it once.

Test Plan:
- Default params, BRAM_LAT=2, each bin 8 words of value 0x0100, offsets all 0 → acc=2048, lvl=min(2048>>8,15)=8; colour bin0 (0x0FF) → 0x077; color_valid exactly 1+7×(8+2+1)=78 cycles after start.
- Bin 3 with start=20, end=10 (empty) and all other bins 1 word of 0x8000 → bin 3 level 0, colour 0x000; other bins acc=32767, lvl=min(32767>>12,15)=7 with OFF_INIT=4; no address issued for bin 3.
- adj_sel=2: 20 up pulses → offset 15, adjusting pulses 11 times; up and down in the same cycle → offset unchanged, adjusting 0; adj_sel=7 → no change.
- Assert reset mid-FETCH of bin 4 → outputs return to reset values at once, offsets back to 4, no color_valid; start after release → normal frame.
- start pulsed again while busy → ignored; exactly one color_valid per accepted start.
- With FFT_COLOR_PEAK_HOLD_EN: frame 1 gives lvl 12, then frames with data 0 → published levels 11, 10, 9; without the macro → 0 immediately.
